// File: rtl/display_bcd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// display_bcd_sequencer_pkg : shared types/constants for the BCD display path
// Revision: 1.0
// ============================================================================
package display_bcd_sequencer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] OVF_CODE   = 4'hE;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_bcd_sequencer_bcd_add3_cell.sv
`default_nettype none
// ============================================================================
// bcd_add3_cell : double-dabble nibble correction (adds 3 when input >= 5)
// Revision: 1.0
// ============================================================================
module bcd_add3_cell (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule
`default_nettype wire

// File: rtl/display_bcd_sequencer.sv
`default_nettype none
// ============================================================================
// display_bcd_sequencer : serial binary-to-BCD converter feeding digit decoders
// Revision: 1.0
// ============================================================================
module display_bcd_sequencer
  import display_bcd_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NDIG  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  value,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              show,
  output logic [4*NDIG-1:0] digits
);

  localparam int ACC_W = 4*NDIG + 4;
  localparam int CW    = cnt_width(WIDTH);

  state_t             r_state;
  state_t             w_state_nx;
  logic [WIDTH-1:0]   r_shift;
  logic [ACC_W-1:0]   r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic               r_show;
  logic [4*NDIG-1:0]  r_digits;

  logic [ACC_W-1:0]   w_adj;
  logic [ACC_W-1:0]   w_acc_nx;
  logic [WIDTH-1:0]   w_shift_nx;
  logic               w_last;
  logic               w_ovf;
  logic [4*NDIG-1:0]  w_blanked;
  logic [4*NDIG-1:0]  w_digits_nx;

  for (genvar g = 0; g < NDIG + 1; g++) begin : g_add3
    bcd_add3_cell u_cell (
      .i_nib (r_acc[4*g +: 4]),
      .o_nib (w_adj[4*g +: 4])
    );
  end

  assign w_acc_nx   = {w_adj[ACC_W-2:0], r_shift[WIDTH-1]};
  assign w_shift_nx = {r_shift[WIDTH-2:0], 1'b0};
  assign w_last     = (r_state == ST_CONV) && (r_cnt == CW'(1));

  // A bit carried out past the guard nibble also counts as not fitting.
  assign w_ovf = (|w_acc_nx[ACC_W-1 -: 4]) | w_adj[ACC_W-1];

  always_comb begin : p_blank
    logic lead;
    lead      = 1'b1;
    w_blanked = w_acc_nx[4*NDIG-1:0];
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (lead && (w_acc_nx[4*i +: 4] == 4'h0)) begin
        w_blanked[4*i +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
  end

  assign w_digits_nx = w_ovf ? {NDIG{OVF_CODE}} : w_blanked;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nx = ST_CONV;
      ST_CONV: if (w_last) w_state_nx = ST_IDLE;
      default:             w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_show   <= 1'b0;
      r_digits <= '0;
    end else begin
      r_busy <= (w_state_nx == ST_CONV);
      r_done <= w_last;
      if ((r_state == ST_IDLE) && start) begin
        r_shift <= value;
        r_acc   <= '0;
        r_cnt   <= CW'(WIDTH);
      end else if (r_state == ST_CONV) begin
        r_shift <= w_shift_nx;
        r_acc   <= w_acc_nx;
        r_cnt   <= r_cnt - CW'(1);
      end
      // The decoders only ever see finished results.
      if (w_last) begin
        r_digits <= w_digits_nx;
        r_ovf    <= w_ovf;
        r_show   <= 1'b1;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;
  assign show     = r_show;
  assign digits   = r_digits;

endmodule
`default_nettype wire

// File: tb/tb_display_bcd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_display_bcd_sequencer : directed self-checking bench (16/5 and 8/2 builds)
// Revision: 1.0
// ============================================================================
module tb_display_bcd_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic        sel;

  logic        busy16, done16, ovf16, show16;
  logic [19:0] dig16;
  logic        busy8, done8, ovf8, show8;
  logic [7:0]  dig8;

  logic        m_busy, m_done, m_ovf, m_show;
  logic [19:0] m_digits;

  int n_checks = 0;
  int n_err    = 0;

  display_bcd_sequencer #(.WIDTH(16), .NDIG(5)) u_dut (
    .clock    (clk),
    .reset    (rst),
    .start    (start && !sel),
    .value    (value),
    .busy     (busy16),
    .done     (done16),
    .overflow (ovf16),
    .show     (show16),
    .digits   (dig16)
  );

  display_bcd_sequencer #(.WIDTH(8), .NDIG(2)) u_dut8 (
    .clock    (clk),
    .reset    (rst),
    .start    (start && sel),
    .value    (value[7:0]),
    .busy     (busy8),
    .done     (done8),
    .overflow (ovf8),
    .show     (show8),
    .digits   (dig8)
  );

  assign m_busy   = sel ? busy8 : busy16;
  assign m_done   = sel ? done8 : done16;
  assign m_ovf    = sel ? ovf8  : ovf16;
  assign m_show   = sel ? show8 : show16;
  assign m_digits = sel ? {12'h000, dig8} : dig16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic conv(input logic s, input logic [15:0] v, input logic [19:0] exp_d,
                      input logic exp_o, input int exp_n, input string tag);
    logic [19:0] prev_d;
    logic        prev_o, prev_s, stable;
    int          n;
    sel = s;
    @(posedge clk); #1;
    start  = 1'b1;
    value  = v;
    prev_d = m_digits;
    prev_o = m_ovf;
    prev_s = m_show;
    @(posedge clk); #1;
    start  = 1'b0;
    value  = 16'($urandom);
    n      = 0;
    stable = 1'b1;
    while (m_busy && n < 40) begin
      if (m_digits !== prev_d || m_ovf !== prev_o || m_show !== prev_s || m_done !== 1'b0)
        stable = 1'b0;
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    check({tag, "_stable"},      32'(stable), 32'd1);
    check({tag, "_done"},        32'(m_done), 32'd1);
    check({tag, "_digits"},      32'(m_digits), 32'(exp_d));
    check({tag, "_ovf"},         32'(m_ovf), 32'(exp_o));
    check({tag, "_show"},        32'(m_show), 32'd1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"},  32'(m_done), 32'd0);
  endtask

  initial begin : p_watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : p_main
    int          nd, at, k1, k2, n;
    logic        busy17;
    logic [19:0] d1, da, db;

    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    sel   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_show",   32'(m_show),   32'd0);
    check("rst_busy",   32'(m_busy),   32'd0);
    check("rst_done",   32'(m_done),   32'd0);
    check("rst_ovf",    32'(m_ovf),    32'd0);
    check("rst_digits", 32'(m_digits), 32'h00000);

    conv(1'b0, 16'd1234,  20'hF1234, 1'b0, 16, "v1234");
    conv(1'b0, 16'd0,     20'hFFFF0, 1'b0, 16, "v0");
    conv(1'b0, 16'd65535, 20'h65535, 1'b0, 16, "v65535");
    conv(1'b0, 16'd10,    20'hFFF10, 1'b0, 16, "v10");

    // start held high with value walking upward from 7
    sel = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; value = 16'd7;
    nd = 0; at = -1; busy17 = 1'b0; d1 = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      value = 16'(8 + i);
      if (m_done) begin
        nd++;
        if (nd == 1) begin at = i; d1 = m_digits; end
      end
      if (i == 17) busy17 = m_busy;
    end
    start = 1'b0;
    check("hold_done_count", 32'(nd), 32'd1);
    check("hold_done_cycle", 32'(at), 32'd16);
    check("hold_digits",     32'(d1), 32'hFFFF7);
    check("hold_restart",    32'(busy17), 32'd1);
    n = 0;
    while (!m_done && n < 40) begin @(posedge clk); #1; n++; end
    check("hold2_done",   32'(m_done),   32'd1);
    check("hold2_digits", 32'(m_digits), 32'hFFF24);

    // reset in the 8th busy cycle of a conversion of 999
    @(posedge clk); #1;
    start = 1'b1; value = 16'd999;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    check("abort_busy_before", 32'(m_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy",   32'(m_busy),   32'd0);
    check("abort_show",   32'(m_show),   32'd0);
    check("abort_digits", 32'(m_digits), 32'h00000);
    check("abort_done",   32'(m_done),   32'd0);
    nd = 0;
    repeat (25) begin @(posedge clk); #1; if (m_done) nd++; end
    check("abort_no_done", 32'(nd), 32'd0);

    // back-to-back: 4321 requested on the done cycle of 1234
    @(posedge clk); #1;
    start = 1'b1; value = 16'd1234;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; k1 = 0; k2 = 0; da = '0; db = '0;
    for (int k = 1; k < 60; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (m_done) begin
        if (nd == 0) begin
          k1 = k; da = m_digits; start = 1'b1; value = 16'd4321;
        end else begin
          k2 = k; db = m_digits;
        end
        nd++;
      end
    end
    check("b2b_count",   32'(nd), 32'd2);
    check("b2b_first",   32'(k1), 32'd16);
    check("b2b_gap",     32'(k2 - k1 - 1), 32'd16);
    check("b2b_digitsA", 32'(da), 32'hF1234);
    check("b2b_digitsB", 32'(db), 32'hF4321);

    conv(1'b1, 16'd200, 20'h000EE, 1'b1, 8, "w8_v200");
    conv(1'b1, 16'd99,  20'h00099, 1'b0, 8, "w8_v99");
    conv(1'b1, 16'd5,   20'h000F5, 1'b0, 8, "w8_v5");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_bcd_sequencer.md
Name: display_bcd_sequencer

Overview:
- Sequential controller that feeds the per-digit 7-segment decoders.
- Accepts a binary result from the processor on a start strobe and converts it to BCD with an iterative shift-add-3 (double-dabble) FSM, one bit per clock.
- Drives a stable, leading-zero-blanked digit bus plus a show flag. Show low makes every decoder display its dash pattern.
- Sits between the processor output register / halt logic and the array of digit decoders.

Parameters:
- WIDTH, 16, bit width of the binary input value.
- NDIG, 5, number of BCD digits produced (one decoder instance per digit).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to convert value; sampled only in IDLE.
- value  input  WIDTH  binary value to convert; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the digits bus updates.
- overflow  output  1  last conversion did not fit in NDIG digits.
- show  output  1  to each decoder's enable: 0 = dashes, 1 = digits.
- digits  output  4*NDIG  packed BCD codes; digits[3:0] is the least significant digit.

Behaviour:
- Reset values: busy=0, done=0, overflow=0, show=0, digits=all 4'h0, state=IDLE, shift counter=0, working registers=0.
- States: IDLE, CONV.
- IDLE: when start=1 on an edge, latch value into the shift register, clear the BCD accumulator, set the counter to WIDTH, go to CONV. Otherwise hold.
- busy is the registered equivalent of (state==CONV), so it is high from the cycle after the accepting edge.
- CONV, each cycle:
  - Every BCD nibble >= 5 gets +3.
  - Then {accumulator, shift register} shifts left one bit.
  - The counter decrements.
- Edge ending the last CONV cycle (counter reaches 0):
  - Update digits, set done=1, set show=1, set overflow, return to IDLE.
  - busy=0 in the same cycle that done=1.
- Latency: start accepted at edge 0 gives done high in the cycle after edge WIDTH (WIDTH cycles of busy).
- Accumulator width is 4*NDIG + 4 (one guard nibble). The guard nibble is nonzero exactly when value > 10^NDIG-1; that sets overflow=1.
- On overflow, all digits are 4'hE, which the decoder blanks. overflow stays at its value until the next done.
- Leading-zero blanking:
  - Scanning from the most significant digit, every leading 0 digit is replaced by 4'hF (decoder blank).
  - Digit 0 is never blanked, so value 0 shows a single "0".
- digits holds its previous value throughout CONV. The decoders never see intermediate accumulator values.
- done is a single-cycle pulse and never stays high two consecutive cycles.
- start while busy is ignored, with no queueing. start in the same cycle done is high is accepted, because the state is IDLE.
- Reset mid-conversion: abort immediately and return to reset values, including show=0 (dashes). No done pulse is produced.
- value is don't-care except on the accepting edge.

Decomposition:
- Shared package holds:
  - State enum {IDLE, CONV}.
  - Constants BLANK_CODE=4'hF and OVF_CODE=4'hE.
  - Function computing counter width as clog2(WIDTH+1).
- One natural combinational sub-module, bcd_add3_cell: 4-bit in, 4-bit out, adds 3 when input >= 5. It is instantiated NDIG+1 times inside the CONV datapath.

Test Plan:
- Reset then idle 5 cycles -> show=0, busy=0, done=0, digits=20'h00000. Then start with value=1234 -> busy high 16 cycles, done pulse in cycle 17, digits=20'hF1234, show=1, overflow=0.
- value=0 -> digits=20'hFFFF0. value=65535 -> digits=20'h65535. value=10 -> digits=20'hFFF10. In each case the digits bus is unchanged while busy.
- start=1 held for 20 cycles, with value changing each cycle from 7 -> exactly one conversion of 7 (digits=20'hFFFF7). The next conversion starts on the done cycle if start is still high.
- reset asserted in the 8th busy cycle of a conversion of 999 -> next cycle busy=0, show=0, digits=20'h00000, and no done pulse.
- WIDTH=8, NDIG=2: value=200 -> overflow=1, digits=8'hEE. Then value=99 -> overflow=0, digits=8'h99. Then value=5 -> digits=8'hF5.
- Back-to-back starts 1234 then 4321, each on its done cycle -> two done pulses exactly 16 cycles apart, with correct digits after each.
